// File: rtl/blit_fetch.sv
// blit_fetch: single-word read cache between the blitter source stage and the SDRAM arbiter.
// Optional snoop coherence against combiner writes is enabled by defining BLIT_FETCH_SNOOP_EN.
module blit_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        p1_read,
  input  logic [25:0] p1_address,
  output logic        p1_ready,
  output logic        p2_valid,
  output logic [7:0]  p2_rdata,
  output logic        mem_read,
  output logic [25:0] mem_address,
  input  logic        mem_accept,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        snoop_write,
  input  logic [25:0] snoop_address
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  logic [1:0]  r_state;
  logic [31:0] r_word;
  logic [23:0] r_tag;
  logic        r_cvalid;
  logic        r_poison;
  logic [1:0]  r_off;
  logic        r_p2_valid;
  logic [7:0]  r_p2_rdata;
  logic        r_mem_read;
  logic [25:0] r_mem_addr;
  logic        w_accept;
  logic        w_hit;
  logic        w_snoop_idle;
  logic        w_snoop_pend;
  logic [7:0]  w_hit_byte;
  logic [7:0]  w_fill_byte;
`ifdef BLIT_FETCH_SNOOP_EN
  assign w_snoop_idle = snoop_write && snoop_address[25:2] == r_tag;
  assign w_snoop_pend = snoop_write && snoop_address[25:2] == r_mem_addr[25:2];
`else
  logic w_unused;
  assign w_unused     = ^{snoop_write, snoop_address};
  assign w_snoop_idle = 1'b0;
  assign w_snoop_pend = 1'b0;
`endif
  assign p1_ready    = r_state == IDLE;
  assign w_accept    = p1_read && p1_ready;
  // A snoop to the cached word beats a same-cycle hit.
  assign w_hit       = r_cvalid && r_tag == p1_address[25:2] && !w_snoop_idle;
  assign w_hit_byte  = r_word[{p1_address[1:0], 3'b000} +: 8];
  assign w_fill_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign p2_valid    = r_p2_valid;
  assign p2_rdata    = r_p2_rdata;
  assign mem_read    = r_mem_read;
  assign mem_address = r_mem_addr;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_tag      <= '0;
      r_cvalid   <= 1'b0;
      r_poison   <= 1'b0;
      r_off      <= '0;
      r_p2_valid <= 1'b0;
      r_p2_rdata <= '0;
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_p2_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_snoop_idle) r_cvalid <= 1'b0;
          if (w_accept && w_hit) begin
            r_p2_valid <= 1'b1;
            r_p2_rdata <= w_hit_byte;
          end else if (w_accept) begin
            r_mem_addr <= {p1_address[25:2], 2'b00};
            r_off      <= p1_address[1:0];
            r_poison   <= 1'b0;
            r_mem_read <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (w_snoop_pend) r_poison <= 1'b1;
          if (mem_accept) begin
            r_mem_read <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (w_snoop_pend) r_poison <= 1'b1;
          if (mem_rvalid) begin
            r_word     <= mem_rdata;
            r_tag      <= r_mem_addr[25:2];
            // A snoop landing with the data still keeps the word out of the cache.
            r_cvalid   <= !(r_poison || w_snoop_pend);
            r_p2_valid <= 1'b1;
            r_p2_rdata <= w_fill_byte;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blit_fetch.sv
// tb_blit_fetch: directed self-checking bench for blit_fetch.
module tb_blit_fetch;
  logic        clock;
  logic        reset;
  logic        p1_read;
  logic [25:0] p1_address;
  logic        p1_ready;
  logic        p2_valid;
  logic [7:0]  p2_rdata;
  logic        mem_read;
  logic [25:0] mem_address;
  logic        mem_accept;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        snoop_write;
  logic [25:0] snoop_address;
  int n_checks = 0;
  int n_errors = 0;

  blit_fetch dut (
    .clock(clock), .reset(reset), .p1_read(p1_read), .p1_address(p1_address),
    .p1_ready(p1_ready), .p2_valid(p2_valid), .p2_rdata(p2_rdata),
    .mem_read(mem_read), .mem_address(mem_address), .mem_accept(mem_accept),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .snoop_write(snoop_write), .snoop_address(snoop_address)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Serves one miss with immediate accept and data; no checking.
  task automatic fill(input logic [25:0] addr, input logic [31:0] data);
    p1_read = 1'b1; p1_address = addr;
    tick;
    p1_read = 1'b0; mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0; mem_rvalid = 1'b1; mem_rdata = data;
    tick;
    mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    n_checks++; if (p1_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", p1_ready); end
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL reset_p2_valid got %b exp 0", p2_valid); end
    n_checks++; if (p2_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_p2_rdata got %h exp 00", p2_rdata); end
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
    n_checks++; if (mem_address !== 26'h0) begin n_errors++; $display("FAIL reset_mem_address got %h exp 0", mem_address); end
  endtask

  task automatic test_miss_basic;
    p1_read = 1'b1; p1_address = 26'h1001;
    tick;
    p1_read = 1'b0;
    n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL miss_mem_read got %b exp 1", mem_read); end
    n_checks++; if (mem_address !== 26'h1000) begin n_errors++; $display("FAIL miss_mem_address got %h exp 1000", mem_address); end
    n_checks++; if (p1_ready !== 1'b0) begin n_errors++; $display("FAIL miss_ready got %b exp 0", p1_ready); end
    mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0;
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL miss_read_drop got %b exp 0", mem_read); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDDCC_BBAA;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL miss_p2_valid got %b exp 1", p2_valid); end
    n_checks++; if (p2_rdata !== 8'hBB) begin n_errors++; $display("FAIL miss_p2_rdata got %h exp bb", p2_rdata); end
    n_checks++; if (p1_ready !== 1'b1) begin n_errors++; $display("FAIL miss_ready_back got %b exp 1", p1_ready); end
    tick;
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL miss_p2_pulse got %b exp 0", p2_valid); end
  endtask

  task automatic test_back_to_back;
    logic [25:0] addrs [3];
    logic [7:0]  exps [3];
    addrs = '{26'h1000, 26'h1002, 26'h1003};
    exps  = '{8'hAA, 8'hCC, 8'hDD};
    p1_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p1_address = addrs[i];
      tick;
      n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid%0d got %b exp 1", i, p2_valid); end
      n_checks++; if (p2_rdata !== exps[i]) begin n_errors++; $display("FAIL b2b_rdata%0d got %h exp %h", i, p2_rdata, exps[i]); end
      n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL b2b_mem_read%0d got %b exp 0", i, mem_read); end
    end
    p1_read = 1'b0;
    tick;
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_idle got %b exp 0", p2_valid); end
  endtask

  task automatic test_delayed_accept;
    p1_read = 1'b1; p1_address = 26'h2002;
    tick;
    p1_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL dly_mem_read%0d got %b exp 1", i, mem_read); end
      n_checks++; if (mem_address !== 26'h2000) begin n_errors++; $display("FAIL dly_addr%0d got %h exp 2000", i, mem_address); end
      n_checks++; if (p1_ready !== 1'b0) begin n_errors++; $display("FAIL dly_ready%0d got %b exp 0", i, p1_ready); end
      n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL dly_p2%0d got %b exp 0", i, p2_valid); end
      tick;
    end
    mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL dly_wait_read%0d got %b exp 0", i, mem_read); end
      n_checks++; if (p1_ready !== 1'b0) begin n_errors++; $display("FAIL dly_wait_ready%0d got %b exp 0", i, p1_ready); end
      n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL dly_wait_p2%0d got %b exp 0", i, p2_valid); end
      tick;
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL dly_p2_valid got %b exp 1", p2_valid); end
    n_checks++; if (p2_rdata !== 8'h33) begin n_errors++; $display("FAIL dly_p2_rdata got %h exp 33", p2_rdata); end
    tick;
  endtask

  task automatic test_snoop_same_cycle;
    fill(26'h1000, 32'hDDCC_BBAA);
    p1_read = 1'b1; p1_address = 26'h1001;
    snoop_write = 1'b1; snoop_address = 26'h1003;
    tick;
    p1_read = 1'b0; snoop_write = 1'b0;
`ifdef BLIT_FETCH_SNOOP_EN
    n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL snp_miss_read got %b exp 1", mem_read); end
    n_checks++; if (mem_address !== 26'h1000) begin n_errors++; $display("FAIL snp_miss_addr got %h exp 1000", mem_address); end
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL snp_miss_p2 got %b exp 0", p2_valid); end
    mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_rdata !== 8'h33) begin n_errors++; $display("FAIL snp_miss_rdata got %h exp 33", p2_rdata); end
`else
    n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL snp_hit_valid got %b exp 1", p2_valid); end
    n_checks++; if (p2_rdata !== 8'hBB) begin n_errors++; $display("FAIL snp_hit_rdata got %h exp bb", p2_rdata); end
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL snp_hit_read got %b exp 0", mem_read); end
`endif
    tick;
  endtask

  task automatic test_snoop_wait;
    p1_read = 1'b1; p1_address = 26'h3000;
    tick;
    p1_read = 1'b0; mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0;
    snoop_write = 1'b1; snoop_address = 26'h3001;
    tick;
    snoop_write = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL snw_valid got %b exp 1", p2_valid); end
    n_checks++; if (p2_rdata !== 8'h55) begin n_errors++; $display("FAIL snw_rdata got %h exp 55", p2_rdata); end
    p1_read = 1'b1; p1_address = 26'h3000;
    tick;
    p1_read = 1'b0;
`ifdef BLIT_FETCH_SNOOP_EN
    n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL snw_remiss_read got %b exp 1", mem_read); end
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL snw_remiss_p2 got %b exp 0", p2_valid); end
    mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_rdata !== 8'h55) begin n_errors++; $display("FAIL snw_remiss_rdata got %h exp 55", p2_rdata); end
`else
    n_checks++; if (p2_valid !== 1'b1) begin n_errors++; $display("FAIL snw_hit_valid got %b exp 1", p2_valid); end
    n_checks++; if (p2_rdata !== 8'h55) begin n_errors++; $display("FAIL snw_hit_rdata got %h exp 55", p2_rdata); end
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL snw_hit_read got %b exp 0", mem_read); end
`endif
    tick;
  endtask

  task automatic test_reset_wait;
    p1_read = 1'b1; p1_address = 26'h4000;
    tick;
    p1_read = 1'b0; mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_checks++; if (p1_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready got %b exp 1", p1_ready); end
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL rst_read got %b exp 0", mem_read); end
    mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL rst_stray_p2 got %b exp 0", p2_valid); end
    tick;
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL rst_stray_p2b got %b exp 0", p2_valid); end
    p1_read = 1'b1; p1_address = 26'h4000;
    tick;
    p1_read = 1'b0;
    n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL rst_remiss_read got %b exp 1", mem_read); end
    n_checks++; if (p2_valid !== 1'b0) begin n_errors++; $display("FAIL rst_remiss_p2 got %b exp 0", p2_valid); end
    mem_accept = 1'b1;
    tick;
    mem_accept = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    tick;
    mem_rvalid = 1'b0;
    n_checks++; if (p2_rdata !== 8'hDD) begin n_errors++; $display("FAIL rst_remiss_rdata got %h exp dd", p2_rdata); end
    tick;
  endtask

  initial begin
    reset = 1'b1; p1_read = 1'b0; p1_address = '0;
    mem_accept = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    snoop_write = 1'b0; snoop_address = '0;
    test_reset;
    test_miss_basic;
    test_back_to_back;
    test_delayed_accept;
    test_snoop_same_cycle;
    test_snoop_wait;
    test_reset_wait;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
